// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives IMEM and fills a one-entry valid/ready slot.
// Optional FETCH_PERF_EN adds saturating fetch_count/stall_count outputs.
module fetch_ctrl #(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [31:0]            out_pc,
    output logic                   fault,
`ifdef FETCH_PERF_EN
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
`endif
    output logic [1:0]             state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [31:0] pc;
    logic        slot_free;
    logic        in_range;
    logic        fetch_en;

    assign imem_addr = pc;
    assign slot_free = !out_valid || out_ready;
    assign in_range  = pc < DEPTH;
    // halt_req suppresses the fetch in the same cycle it moves RUN to HALT
    assign fetch_en  = (state == S_RUN) && slot_free && !redirect_valid
                       && !halt_req && in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state <= S_HALT;
                    end else if (!redirect_valid && slot_free && !in_range) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (start && !halt_req)
                        state <= S_RUN;
                end
                default: ;
            endcase

            if (state == S_FAULT) begin
                out_valid <= 1'b0;
            end else if (redirect_valid) begin
                pc        <= redirect_pc;
                out_valid <= 1'b0;
            end else if (fetch_en) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc + 32'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_en && fetch_count != '1)
                fetch_count <= fetch_count + 32'd1;
            if (state == S_RUN && out_valid && !out_ready && stall_count != '1)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: table of per-cycle vectors plus hand sequences for
// async reset, IDLE start+halt, HALT drain under backpressure and the optional perf counters.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a + 32'd1) * 32'h9E37_79B9;
    endfunction

    assign imem_instr = word(imem_addr);

    fetch_ctrl #(.IMEM_DEPTH(256), .INSTR_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fault(fault),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count), .stall_count(stall_count),
`endif
        .state(state)
    );

    typedef struct {
        logic        start;
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        logic [1:0]  exp_state;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, h, r, input logic [31:0] rp, input logic rdy,
                                input logic v, input logic [31:0] p, a,
                                input logic [1:0] st, input logic f);
        vec_t x;
        x.start = s; x.halt = h; x.redir = r; x.rpc = rp; x.ready = rdy;
        x.exp_valid = v; x.exp_pc = p; x.exp_addr = a; x.exp_state = st; x.exp_fault = f;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, h, r, input logic [31:0] rp, input logic rdy);
        start = s; halt_req = h; redirect_valid = r; redirect_pc = rp; out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".pc"},    out_pc,         32'd0);
        chk({tag, ".instr"}, out_instr,      32'd0);
        chk({tag, ".addr"},  imem_addr,      32'd0);
        chk({tag, ".state"}, 32'(state),     32'd0);
        chk({tag, ".fault"}, 32'(fault),     32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"},  fetch_count,    32'd0);
        chk({tag, ".scnt"},  stall_count,    32'd0);
`endif
    endtask

    initial begin
        //            st h  r  rpc  rdy  valid pc  addr state fault
        vecs.push_back(mk(1, 0, 0, 0,   1,   0,  0,   0,  1, 0)); // start
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  0,   1,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  1,   2,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  2,   3,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   1,  2,   3,  1, 0)); // stall x3
        vecs.push_back(mk(0, 0, 0, 0,   0,   1,  2,   3,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   1,  2,   3,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  3,   4,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  4,   5,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  5,   6,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  6,   7,  1, 0));
        vecs.push_back(mk(0, 0, 1, 25,  1,   0,  6,  25,  1, 0)); // redirect flushes
        vecs.push_back(mk(0, 0, 0, 0,   1,   1, 25,  26,  1, 0));
        vecs.push_back(mk(0, 0, 1, 9,   1,   0, 25,   9,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1,  9,  10,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1, 10,  11,  1, 0));
        vecs.push_back(mk(0, 1, 0, 0,   1,   0, 10,  11,  2, 0)); // halt, drain
        vecs.push_back(mk(0, 1, 0, 0,   1,   0, 10,  11,  2, 0));
        vecs.push_back(mk(1, 1, 0, 0,   1,   0, 10,  11,  2, 0)); // start ignored under halt
        vecs.push_back(mk(1, 0, 0, 0,   1,   0, 10,  11,  1, 0)); // resume
        vecs.push_back(mk(0, 0, 0, 0,   1,   1, 11,  12,  1, 0));
        vecs.push_back(mk(0, 1, 1, 40,  1,   0, 11,  40,  2, 0)); // halt + redirect
        vecs.push_back(mk(1, 0, 0, 0,   1,   0, 11,  40,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   1, 40,  41,  1, 0));
        vecs.push_back(mk(0, 0, 1, 255, 1,   0, 40, 255,  1, 0)); // last valid word
        vecs.push_back(mk(0, 0, 0, 0,   1,   1, 255, 256, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1,   0, 255, 256, 3, 1)); // fault
        vecs.push_back(mk(1, 0, 1, 3,   1,   0, 255, 256, 3, 1)); // ignored in FAULT
        vecs.push_back(mk(0, 1, 0, 0,   1,   0, 255, 256, 3, 1));

        #2;
        chk_reset_outputs("rst_held");
        #10 rst = 1'b0;   // t=12, between edges
        chk_reset_outputs("rst_rel");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].halt, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            tick();
            chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.addr", i),  imem_addr,      vecs[i].exp_addr);
            chk($sformatf("v%0d.state", i), 32'(state),     32'(vecs[i].exp_state));
            chk($sformatf("v%0d.fault", i), 32'(fault),     32'(vecs[i].exp_fault));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d.pc", i),    out_pc,    vecs[i].exp_pc);
                chk($sformatf("v%0d.instr", i), out_instr, word(vecs[i].exp_pc));
            end
        end

        // Async reset clears the sticky fault without a clock edge
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_fault");
        rst = 1'b0;

        // IDLE: start+halt goes to RUN; HALT keeps an unaccepted slot until out_ready
        tick();
        drive(1, 1, 0, 0, 0);
        tick();
        chk("sh.state", 32'(state), 32'd1);
        chk("sh.valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("sh.fetch_valid", 32'(out_valid), 32'd1);
        chk("sh.fetch_pc", out_pc, 32'd0);
        drive(0, 1, 0, 0, 0);
        tick();
        chk("hd.state", 32'(state), 32'd2);
        chk("hd.hold_valid", 32'(out_valid), 32'd1);
        chk("hd.hold_instr", out_instr, word(32'd0));
        drive(0, 1, 0, 0, 1);
        tick();
        chk("hd.drain_valid", 32'(out_valid), 32'd0);
        chk("hd.addr", imem_addr, 32'd1);

        // Run to pc=7 with one stall cycle, then reset mid-cycle
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        drive(1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("mr.pc", out_pc, 32'd6);
        chk("mr.instr", out_instr, word(32'd6));
        chk("mr.addr", imem_addr, 32'd7);
`ifdef FETCH_PERF_EN
        chk("mr.fcnt", fetch_count, 32'd7);
        chk("mr.scnt", stall_count, 32'd1);
`endif
        #3 rst = 1'b1;
        #1 chk_reset_outputs("rst_midrun");
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
